id_stage_pipe: RTL and testbench

- Registered RV32I decode stage with valid/ready handshakes on both sides.
- Sits between the IF/ID register and EX and drives the combinational register-file read ports.
- Generalises the combinational decoder with an N-source forwarding network in priority order, and never forwards x0.
- Adds load-use stall with bubble insertion, synchronous flush for redirects, and a decoded branch/JAL target.

---
 rtl/id_pkg.sv | 60 ++++++
 rtl/id_stage_pipe_if.sv | 58 +++++
 rtl/id_fwd_sel.sv | 38 +++
 rtl/id_stage_pipe.sv | 269 ++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// RV32I decode stage shared definitions: opcodes, immediate extraction, decoded-op control word.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package id_pkg;

    // Major opcodes (inst[6:0]) recognised by the decode stage.
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    // Control part of a decoded op; data fields are XLEN-wide and live in the stage itself.
    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       alt;
        logic       we;
    } dec_ctl_t;

    // Operand A / B source selects produced by the decoder.
    typedef enum logic [1:0] {
        OPA_ZERO,
        OPA_RS1,
        OPA_PC
    } opa_e;

    typedef enum logic [1:0] {
        OPB_ZERO,
        OPB_RS2,
        OPB_IMM,
        OPB_FOUR
    } opb_e;

    // Immediate extraction, 32-bit sign-extended results.
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bundle of the decode stage's IF-side, regfile, forwarding, flush and EX-side signals.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface id_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int RAW  = 5
);
    // IF side
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_pc;
    logic [31:0]          in_inst;
    // register-file read ports (combinational)
    logic                 re1;
    logic                 re2;
    logic [RAW-1:0]       ra1;
    logic [RAW-1:0]       ra2;
    logic [XLEN-1:0]      rn1;
    logic [XLEN-1:0]      rn2;
    // forwarding sources, index 0 = youngest / highest priority
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD-1:0]      fwd_pend;
    logic [NFWD*RAW-1:0]  fwd_wa;
    logic [NFWD*XLEN-1:0] fwd_wn;
    // redirect
    logic                 flush;
    // EX side
    logic                 out_valid;
    logic                 out_ready;
    logic [6:0]           out_op;
    logic [2:0]           out_f3;
    logic                 out_alt;
    logic [XLEN-1:0]      out_a;
    logic [XLEN-1:0]      out_b;
    logic [XLEN-1:0]      out_imm;
    logic [RAW-1:0]       out_wa;
    logic                 out_we;
    logic [XLEN-1:0]      out_tgt;

    // Environment view (fetch, regfile, later stages).
    modport master (
        output in_valid, in_pc, in_inst, rn1, rn2,
        output fwd_we, fwd_pend, fwd_wa, fwd_wn, flush, out_ready,
        input  in_ready, re1, re2, ra1, ra2,
        input  out_valid, out_op, out_f3, out_alt, out_a, out_b,
        input  out_imm, out_wa, out_we, out_tgt
    );

    // Decode stage view.
    modport slave (
        input  in_valid, in_pc, in_inst, rn1, rn2,
        input  fwd_we, fwd_pend, fwd_wa, fwd_wn, flush, out_ready,
        output in_ready, re1, re2, ra1, ra2,
        output out_valid, out_op, out_f3, out_alt, out_a, out_b,
        output out_imm, out_wa, out_we, out_tgt
    );
endinterface

// File: rtl/id_fwd_sel.sv
// Per-operand forwarding select: picks highest-priority matching source, else regfile data; x0 reads 0.
// Latency: combinational.
// Backpressure: none; pend reports that the winning source has no result yet.
// Ports: ra (read address), rn (regfile data), fwd_* (packed sources), val (operand), pend (stall request).
module id_fwd_sel #(
    parameter int NFWD = 2,
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic [RAW-1:0]       ra,
    input  logic [XLEN-1:0]      rn,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_pend,
    input  logic [NFWD*RAW-1:0]  fwd_wa,
    input  logic [NFWD*XLEN-1:0] fwd_wn,
    output logic [XLEN-1:0]      val,
    output logic                 pend
);

    always_comb begin
        val  = rn;
        pend = 1'b0;
        // Walk from lowest to highest priority so the youngest match is written last and wins;
        // a pending younger match therefore masks any older ready value.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_wa[i*RAW +: RAW] == ra)) begin
                val  = fwd_wn[i*XLEN +: XLEN];
                pend = fwd_pend[i];
            end
        end
        // x0 is hard-wired: never forward to it and never stall on it.
        if (ra == '0) begin
            val  = '0;
            pend = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage with forwarding, load-use stall/bubble and flush.
// Latency: one cycle from in_valid&&in_ready to out_valid.
// Backpressure: holds outputs while out_valid&&!out_ready; in_ready drops on load-use hazard or full stage.
// Ports: clk, rst (sync, active-high) and bus (slave view of id_stage_pipe_if).
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int RAW  = 5
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [31:0]    inst;
    logic [6:0]     opc;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;

    assign inst = bus.in_inst;
    assign opc  = inst[6:0];
    assign rd   = RAW'(inst[11:7]);
    assign rs1  = RAW'(inst[19:15]);
    assign rs2  = RAW'(inst[24:20]);

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // ------------------------------------------------------------------
    // Opcode decode: control word, read enables, operand selects, imm, target
    // ------------------------------------------------------------------
    dec_ctl_t        ctl_c;
    logic            re1_c;
    logic            re2_c;
    logic            wr_c;
    logic            shamt_c;
    opa_e            a_sel;
    opb_e            b_sel;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] bimm_c;
    logic [XLEN-1:0] tgt_c;
    logic [RAW-1:0]  wa_c;

    always_comb begin
        ctl_c     = '0;
        ctl_c.op  = opc;
        ctl_c.f3  = inst[14:12];
        ctl_c.alt = inst[30];
        re1_c     = 1'b0;
        re2_c     = 1'b0;
        wr_c      = 1'b0;
        shamt_c   = 1'b0;
        a_sel     = OPA_ZERO;
        b_sel     = OPB_ZERO;
        imm_c     = '0;
        bimm_c    = '0;
        tgt_c     = '0;
        wa_c      = '0;

        case (opc)
            LUI: begin
                wr_c  = 1'b1;
                imm_c = sx(imm_u(inst));
                b_sel = OPB_IMM;
            end
            AUIPC: begin
                wr_c  = 1'b1;
                imm_c = sx(imm_u(inst));
                a_sel = OPA_PC;
                b_sel = OPB_IMM;
            end
            OP: begin
                wr_c  = 1'b1;
                re1_c = 1'b1;
                re2_c = 1'b1;
                a_sel = OPA_RS1;
                b_sel = OPB_RS2;
            end
            OPIMM: begin
                wr_c    = 1'b1;
                re1_c   = 1'b1;
                imm_c   = sx(imm_i(inst));
                a_sel   = OPA_RS1;
                b_sel   = OPB_IMM;
                // SLLI/SRLI/SRAI: operand B is the raw shift amount, not the I-immediate
                shamt_c = (inst[13:12] == 2'b01);
            end
            LOAD: begin
                wr_c  = 1'b1;
                re1_c = 1'b1;
                imm_c = sx(imm_i(inst));
                a_sel = OPA_RS1;
                b_sel = OPB_IMM;
            end
            STORE: begin
                re1_c = 1'b1;
                re2_c = 1'b1;
                imm_c = sx(imm_s(inst));
                a_sel = OPA_RS1;
                b_sel = OPB_RS2;
            end
            BRANCH: begin
                re1_c = 1'b1;
                re2_c = 1'b1;
                imm_c = sx(imm_b(inst));
                a_sel = OPA_RS1;
                b_sel = OPB_RS2;
                tgt_c = bus.in_pc + imm_c;
            end
            JAL: begin
                wr_c  = 1'b1;
                imm_c = sx(imm_j(inst));
                a_sel = OPA_PC;
                b_sel = OPB_FOUR;
                tgt_c = bus.in_pc + imm_c;
            end
            JALR: begin
                // Target is rs1+imm, formed in EX; only the operands are prepared here.
                wr_c  = 1'b1;
                re1_c = 1'b1;
                imm_c = sx(imm_i(inst));
                a_sel = OPA_RS1;
                b_sel = OPB_IMM;
            end
            default: begin
                // Unknown opcodes flow through as NOPs.
            end
        endcase

        bimm_c   = shamt_c ? XLEN'(inst[24:20]) : imm_c;
        // Writes to x0 are suppressed; the destination is only meaningful when writing.
        ctl_c.we = wr_c && (rd != '0);
        wa_c     = ctl_c.we ? rd : '0;
    end

    // Register-file read ports are quiet when no instruction is offered.
    logic re1_o;
    logic re2_o;
    logic [RAW-1:0] ra1_o;
    logic [RAW-1:0] ra2_o;

    assign re1_o   = bus.in_valid && re1_c;
    assign re2_o   = bus.in_valid && re2_c;
    assign ra1_o   = re1_o ? rs1 : '0;
    assign ra2_o   = re2_o ? rs2 : '0;
    assign bus.re1 = re1_o;
    assign bus.re2 = re2_o;
    assign bus.ra1 = ra1_o;
    assign bus.ra2 = ra2_o;

    // ------------------------------------------------------------------
    // Forwarding network, one selector per source operand
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            pend1;
    logic            pend2;

    id_fwd_sel #(.NFWD(NFWD), .XLEN(XLEN), .RAW(RAW)) u_fwd1 (
        .ra       (ra1_o),
        .rn       (bus.rn1),
        .fwd_we   (bus.fwd_we),
        .fwd_pend (bus.fwd_pend),
        .fwd_wa   (bus.fwd_wa),
        .fwd_wn   (bus.fwd_wn),
        .val      (rs1_val),
        .pend     (pend1)
    );

    id_fwd_sel #(.NFWD(NFWD), .XLEN(XLEN), .RAW(RAW)) u_fwd2 (
        .ra       (ra2_o),
        .rn       (bus.rn2),
        .fwd_we   (bus.fwd_we),
        .fwd_pend (bus.fwd_pend),
        .fwd_wa   (bus.fwd_wa),
        .fwd_wn   (bus.fwd_wn),
        .val      (rs2_val),
        .pend     (pend2)
    );

    logic [XLEN-1:0] a_c;
    logic [XLEN-1:0] b_c;

    always_comb begin
        a_c = '0;
        b_c = '0;
        case (a_sel)
            OPA_RS1: a_c = rs1_val;
            OPA_PC:  a_c = bus.in_pc;
            default: a_c = '0;
        endcase
        case (b_sel)
            OPB_RS2:  b_c = rs2_val;
            OPB_IMM:  b_c = bimm_c;
            OPB_FOUR: b_c = XLEN'(32'd4);
            default:  b_c = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic vld_q;
    logic hazard;
    logic in_rdy;
    logic fire;

    // pend1/pend2 are already masked for x0 and for unused operands (ra forced to 0).
    assign hazard       = bus.in_valid && (pend1 || pend2);
    // Flush always swallows the offered instruction so fetch can move to the new path.
    assign in_rdy       = bus.flush || (!hazard && (!vld_q || bus.out_ready));
    assign fire         = bus.in_valid && in_rdy;
    assign bus.in_ready = in_rdy;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    dec_ctl_t        ctl_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] tgt_q;
    logic [RAW-1:0]  wa_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            ctl_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            tgt_q <= '0;
            wa_q  <= '0;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (fire) begin
            // An all-zero word is an IF bubble: consumed but never issued.
            vld_q <= (inst != 32'd0);
            ctl_q <= ctl_c;
            a_q   <= a_c;
            b_q   <= b_c;
            imm_q <= imm_c;
            tgt_q <= tgt_c;
            wa_q  <= wa_c;
        end else if (bus.out_ready) begin
            // Held op drained with nothing behind it (hazard or idle): present a bubble.
            vld_q <= 1'b0;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_op    = ctl_q.op;
    assign bus.out_f3    = ctl_q.f3;
    assign bus.out_alt   = ctl_q.alt;
    assign bus.out_we    = ctl_q.we;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_tgt   = tgt_q;
    assign bus.out_wa    = wa_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expected ops queued at issue time, popped by an output monitor.
// Latency: n/a.
// Backpressure: bench drives out_ready directly.
module tb_id_stage_pipe;
    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int RAW  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)) bus ();

    id_stage_pipe #(.XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [4:0] wa, input logic we, input logic [31:0] tgt);
        exp_t e;
        e.op = op; e.f3 = f3; e.alt = alt; e.a = a; e.b = b;
        e.imm = imm; e.wa = wa; e.we = we; e.tgt = tgt;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            act = {bus.out_op, bus.out_f3, bus.out_alt, bus.out_a, bus.out_b,
                   bus.out_imm, bus.out_wa, bus.out_we, bus.out_tgt};
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_issue: got %h, expected nothing", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL issue: got op=%h f3=%h alt=%b a=%h b=%h imm=%h wa=%0d we=%b tgt=%h, expected op=%h f3=%h alt=%b a=%h b=%h imm=%h wa=%0d we=%b tgt=%h",
                             act.op, act.f3, act.alt, act.a, act.b, act.imm, act.wa, act.we, act.tgt,
                             e.op, e.f3, e.alt, e.a, e.b, e.imm, e.wa, e.we, e.tgt);
                end
            end
        end
    end

    task automatic set_fwd(input int i, input logic we, input logic pend,
                           input logic [4:0] wa, input logic [31:0] wn);
        bus.fwd_we[i]              = we;
        bus.fwd_pend[i]            = pend;
        bus.fwd_wa[i*RAW +: RAW]   = wa;
        bus.fwd_wn[i*XLEN +: XLEN] = wn;
    endtask

    task automatic clr_fwd();
        bus.fwd_we   = '0;
        bus.fwd_pend = '0;
        bus.fwd_wa   = '0;
        bus.fwd_wn   = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction and wait (bounded) for acceptance; called just after a rising edge.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input bit push, input exp_t e);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        if (push) sb.push_back(e);
        @(negedge clk);
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0 for inst %h, expected 1", inst);
        end
        cyc();
        bus.in_valid = 1'b0;
    endtask

    localparam logic [31:0] I_ADD3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADDI5  = 32'h00700293; // addi x5,x0,7
    localparam logic [31:0] I_AUIPC  = 32'h00001517; // auipc x10,1
    localparam logic [31:0] I_SRAI   = 32'h40365593; // srai x11,x12,3
    localparam logic [31:0] I_LW     = 32'hFFC72683; // lw   x13,-4(x14)
    localparam logic [31:0] I_SW     = 32'h00F82423; // sw   x15,8(x16)
    localparam logic [31:0] I_BEQ    = 32'hFE208CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_JALR   = 32'h00C280E7; // jalr x1,12(x5)
    localparam logic [31:0] I_FENCE  = 32'h0000000F;
    localparam logic [31:0] I_ADDIX0 = 32'h00508013; // addi x0,x1,5
    localparam logic [31:0] I_ADD6   = 32'h00420333; // add  x6,x4,x4
    localparam logic [31:0] I_JAL    = 32'h008000EF; // jal  x1,+8
    localparam logic [31:0] I_ADDI7  = 32'h00100393; // addi x7,x0,1
    localparam logic [31:0] I_LUI    = 32'h123454B7; // lui  x9,0x12345

    exp_t none;

    initial begin
        none = '0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.rn1       = '0;
        bus.rn2       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        clr_fwd();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_a", bus.out_a, 0);
        chk("rst_tgt", bus.out_tgt, 0);
        chk("rst_op", 32'(bus.out_op), 0);

        // Read ports idle without in_valid, active with it
        bus.in_inst = I_ADD3;
        #1;
        chk("idle_re1", 32'(bus.re1), 0);
        chk("idle_ra2", 32'(bus.ra2), 0);
        bus.in_valid = 1'b1;
        #1;
        chk("rd_re2", 32'(bus.re2), 1);
        chk("rd_ra1", 32'(bus.ra1), 1);
        chk("rd_ra2", 32'(bus.ra2), 2);
        bus.in_valid = 1'b0;
        cyc();

        // Streaming decode with EX always ready
        bus.out_ready = 1'b1;
        bus.rn1 = 32'h33;
        bus.rn2 = 32'h44;
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h11);
        set_fwd(1, 1'b1, 1'b0, 5'd1, 32'h22);
        send(I_ADD3, 32'h0, 1, mk(7'h33, 3'd0, 1'b0, 32'h11, 32'h44, 32'h0, 5'd3, 1'b1, 32'h0));
        set_fwd(0, 1'b0, 1'b0, 5'd1, 32'h11);
        send(I_ADD3, 32'h4, 1, mk(7'h33, 3'd0, 1'b0, 32'h22, 32'h44, 32'h0, 5'd3, 1'b1, 32'h0));
        clr_fwd();
        set_fwd(0, 1'b1, 1'b0, 5'd0, 32'hFF);
        send(I_ADDI5, 32'h8, 1, mk(7'h13, 3'd0, 1'b0, 32'h0, 32'h7, 32'h7, 5'd5, 1'b1, 32'h0));
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hFF);
        send(I_ADDI5, 32'hC, 1, mk(7'h13, 3'd0, 1'b0, 32'h0, 32'h7, 32'h7, 5'd5, 1'b1, 32'h0));
        clr_fwd();
        bus.rn1 = 32'hAAAA0000;
        bus.rn2 = 32'h0BBB0000;
        send(I_AUIPC, 32'h200, 1, mk(7'h17, 3'd1, 1'b0, 32'h200, 32'h1000, 32'h1000, 5'd10, 1'b1, 32'h0));
        send(I_SRAI, 32'h204, 1, mk(7'h13, 3'd5, 1'b1, 32'hAAAA0000, 32'h3, 32'h403, 5'd11, 1'b1, 32'h0));
        send(I_LW, 32'h208, 1, mk(7'h03, 3'd2, 1'b1, 32'hAAAA0000, 32'hFFFFFFFC, 32'hFFFFFFFC, 5'd13, 1'b1, 32'h0));
        send(I_SW, 32'h20C, 1, mk(7'h23, 3'd2, 1'b0, 32'hAAAA0000, 32'h0BBB0000, 32'h8, 5'd0, 1'b0, 32'h0));
        send(I_BEQ, 32'h300, 1, mk(7'h63, 3'd0, 1'b1, 32'hAAAA0000, 32'h0BBB0000, 32'hFFFFFFF8, 5'd0, 1'b0, 32'h2F8));
        send(I_JALR, 32'h304, 1, mk(7'h67, 3'd0, 1'b0, 32'hAAAA0000, 32'hC, 32'hC, 5'd1, 1'b1, 32'h0));
        send(I_FENCE, 32'h308, 1, mk(7'h0F, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0));
        send(32'h0, 32'h30C, 0, none);
        send(I_ADDIX0, 32'h310, 1, mk(7'h13, 3'd0, 1'b0, 32'hAAAA0000, 32'h5, 32'h5, 5'd0, 1'b0, 32'h0));
        set_fwd(0, 1'b1, 1'b0, 5'd4, 32'h66);
        set_fwd(1, 1'b1, 1'b1, 5'd4, 32'h77);
        send(I_ADD6, 32'h314, 1, mk(7'h33, 3'd0, 1'b0, 32'h66, 32'h66, 32'h0, 5'd6, 1'b1, 32'h0));
        clr_fwd();
        repeat (2) cyc();
        chk("stream_drained", 32'(sb.size()), 0);

        // Load-use stall behind a valid op
        send(I_ADDI5, 32'h3FC, 1, mk(7'h13, 3'd0, 1'b0, 32'h0, 32'h7, 32'h7, 5'd5, 1'b1, 32'h0));
        set_fwd(0, 1'b1, 1'b1, 5'd4, 32'h55);
        bus.in_valid = 1'b1;
        bus.in_inst  = I_ADD6;
        bus.in_pc    = 32'h400;
        sb.push_back(mk(7'h33, 3'd0, 1'b0, 32'h55, 32'h55, 32'h0, 5'd6, 1'b1, 32'h0));
        @(negedge clk);
        chk("lu_stall_ready", 32'(bus.in_ready), 0);
        chk("lu_prev_valid", 32'(bus.out_valid), 1);
        cyc();
        @(negedge clk);
        chk("lu_bubble_valid", 32'(bus.out_valid), 0);
        chk("lu_bubble_ready", 32'(bus.in_ready), 0);
        cyc();
        set_fwd(0, 1'b1, 1'b0, 5'd4, 32'h55);
        @(negedge clk);
        chk("lu_release_ready", 32'(bus.in_ready), 1);
        cyc();
        bus.in_valid = 1'b0;
        clr_fwd();
        @(negedge clk);
        chk("lu_issue_valid", 32'(bus.out_valid), 1);
        repeat (2) cyc();

        // Backpressure hold
        bus.out_ready = 1'b0;
        send(I_JAL, 32'h100, 1, mk(7'h6F, 3'd0, 1'b0, 32'h100, 32'h4, 32'h8, 5'd1, 1'b1, 32'h108));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_tgt", bus.out_tgt, 32'h108);
            chk("bp_a", bus.out_a, 32'h100);
            chk("bp_b", bus.out_b, 32'h4);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        cyc();

        // Flush with a held op and a BEQ at the input
        bus.out_ready = 1'b0;
        send(I_ADDI7, 32'h600, 0, none);
        bus.in_valid = 1'b1;
        bus.in_inst  = I_BEQ;
        bus.in_pc    = 32'h604;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("fl_held_valid", 32'(bus.out_valid), 1);
        chk("fl_in_ready", 32'(bus.in_ready), 1);
        cyc();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fl_drop_valid", 32'(bus.out_valid), 0);
            cyc();
        end

        // Reset in the middle of backpressure
        bus.out_ready = 1'b0;
        send(I_LUI, 32'h500, 0, none);
        @(negedge clk);
        chk("lui_hold_valid", 32'(bus.out_valid), 1);
        chk("lui_hold_b", bus.out_b, 32'h12345000);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(bus.out_valid), 0);
        chk("mrst_b", bus.out_b, 0);
        chk("mrst_imm", bus.out_imm, 0);
        chk("mrst_wa", 32'(bus.out_wa), 0);
        chk("mrst_we", 32'(bus.out_we), 0);
        chk("mrst_op", 32'(bus.out_op), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
